// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage of the MIPS core.
// Holds the PC, drives the combinational instruction memory and registers
// the returned word into the IF/ID register. Stall and the branch, jump and
// jump-register redirects resolve against the instruction held in IF/ID.
// Optional feature macro: BUSCA_ALINHAMENTO_EN. When it is defined, a JR to
// a misaligned address raises a sticky error and halts the stage.
module unidade_busca #(
    parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        desvio,
    input  logic [15:0] imediato,
    input  logic        salto,
    input  logic [25:0] alvo,
    input  logic        salto_reg,
    input  logic [31:0] registrador,
    output logic [31:0] addr,
    input  logic [31:0] instrucao,
    output logic [31:0] if_instrucao,
    output logic [31:0] if_pc4,
    output logic        if_valido,
    output logic        erro_alinhamento
);

    logic [31:0] pc;
    logic        parado;

    // Branch target: word offset sign-extended, scaled by 4, added to PC+4.
    function automatic logic [31:0] alvo_desvio(input logic [31:0] base,
                                                input logic [15:0] imm);
        logic signed [31:0] desloc;
        desloc = {{14{imm[15]}}, imm, 2'b00};
        return base + desloc;
    endfunction

    // Jump target: upper four bits of PC+4 with the 26-bit word index.
    function automatic logic [31:0] alvo_salto(input logic [31:0] base,
                                               input logic [25:0] campo);
        return {base[31:28], campo, 2'b00};
    endfunction

    // Redirects only count when IF/ID holds a real instruction.
    logic redir_jr, redir_j, redir_b;
    assign redir_jr = if_valido && salto_reg;
    assign redir_j  = if_valido && salto;
    assign redir_b  = if_valido && desvio;

    // Fetch address is the PC itself.
    assign addr = pc;

`ifdef BUSCA_ALINHAMENTO_EN
    assign parado           = erro_alinhamento;
`else
    assign parado           = 1'b0;
    assign erro_alinhamento = 1'b0;
`endif

    // PC and IF/ID update: reset, halt, stall, JR, J, branch, sequential.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= PC_INICIAL;
            if_instrucao <= 32'h0;
            if_pc4       <= 32'h0;
            if_valido    <= 1'b0;
`ifdef BUSCA_ALINHAMENTO_EN
            erro_alinhamento <= 1'b0;
`endif
        end else if (parado || stall) begin
            // hold everything; dropped redirects are re-presented by decode
        end else if (redir_jr) begin
`ifdef BUSCA_ALINHAMENTO_EN
            if (registrador[1:0] != 2'b00) begin
                if_valido        <= 1'b0;
                erro_alinhamento <= 1'b1;
            end else begin
                pc           <= registrador;
                if_instrucao <= 32'h0;
                if_valido    <= 1'b0;
            end
`else
            pc           <= registrador & 32'hFFFF_FFFC;
            if_instrucao <= 32'h0;
            if_valido    <= 1'b0;
`endif
        end else if (redir_j) begin
            pc           <= alvo_salto(if_pc4, alvo);
            if_instrucao <= 32'h0;
            if_valido    <= 1'b0;
        end else if (redir_b) begin
            pc           <= alvo_desvio(if_pc4, imediato);
            if_instrucao <= 32'h0;
            if_valido    <= 1'b0;
        end else begin
            // IF -> IF/ID boundary
            if_instrucao <= instrucao;
            if_pc4       <= pc + 32'd4;
            if_valido    <= 1'b1;
            pc           <= pc + 32'd4;
        end
    end

endmodule
